// File: rtl/cmp_arbiter.sv
// cmp_arbiter
//   Round-robin arbiter that shares one pipelined less-than comparator
//   among N requesters. A granted requester's operands are registered
//   onto cmp_a/cmp_b. A tag pipeline holds the requester index alongside
//   the comparator latency, so each result comes back to the requester
//   that issued it, in issue order, one compare per cycle.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   hold              blocks new grants; in-flight compares still drain
//   req_valid[N]      per-requester compare request
//   req_a/req_b[N*W]  operands; requester i uses slice [i*W +: W]
//   req_ready[N]      one-hot-or-zero grant (combinational)
//   cmp_a/cmp_b[W]    registered operands to the shared comparator
//   cmp_less          comparator result (A < B)
//   resp_valid[N]     one-hot-or-zero, one-cycle result pulse
//   resp_less         result bit, meaningful while resp_valid != 0
//   idle              no compare in flight and no grant this cycle
module cmp_arbiter #(
    parameter int N   = 4,
    parameter int W   = 22,
    parameter int LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hold,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   cmp_a,
    output logic [W-1:0]   cmp_b,
    input  logic           cmp_less,
    output logic [N-1:0]   resp_valid,
    output logic           resp_less,
    output logic           idle
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic [IW:0]   cand;
    logic [IW-1:0] idx;
    logic          xfer;

    logic [W-1:0]  cmp_a_q, cmp_a_d;
    logic [W-1:0]  cmp_b_q, cmp_b_d;

    logic [LAT:0]  tag_vld_q, tag_vld_d;
    logic [IW-1:0] tag_idx_q [0:LAT];
    logic [IW-1:0] tag_idx_d [0:LAT];
    logic [N-1:0]  resp_valid_q, resp_valid_d;

    // Grant stage: round-robin search starting at ptr_q, modulo N.
    // ptr_q < N and k < N, so one conditional subtraction wraps the sum.
    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        idx   = '0;
        if (!rst && !hold) begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, ptr_q} + (IW+1)'(k);
                if (cand >= (IW+1)'(N)) begin
                    cand = cand - (IW+1)'(N);
                end
                idx = cand[IW-1:0];
                if (grant == '0 && req_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gidx       = idx;
                end
            end
        end
    end

    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    assign xfer = |grant;

    always_comb begin
        ptr_d   = ptr_q;
        cmp_a_d = cmp_a_q;
        cmp_b_d = cmp_b_q;
        if (xfer) begin
            ptr_d   = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
            cmp_a_d = req_a[int'(gidx)*W +: W];
            cmp_b_d = req_b[int'(gidx)*W +: W];
        end
    end

    // Tag stage: the index rides LAT+1 stages, matching the operand
    // register plus the comparator latency; resp_valid is one more flop.
    always_comb begin
        tag_vld_d    = {tag_vld_q[LAT-1:0], xfer};
        tag_idx_d[0] = gidx;
        for (int k = 1; k <= LAT; k++) begin
            tag_idx_d[k] = tag_idx_q[k-1];
        end
        resp_valid_d = '0;
        if (tag_vld_q[LAT]) begin
            resp_valid_d[tag_idx_q[LAT]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            tag_vld_q    <= '0;
            resp_valid_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
            tag_vld_q    <= tag_vld_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Indices are qualified by tag_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k <= LAT; k++) begin
            tag_idx_q[k] <= tag_idx_d[k];
        end
    end

    // Output stage
    assign req_ready  = grant;
    assign cmp_a      = cmp_a_q;
    assign cmp_b      = cmp_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_less  = cmp_less;
    assign idle       = ~|tag_vld_q & ~|grant;

endmodule

// File: tb/tb_cmp_arbiter.sv
module tb_cmp_arbiter;

    localparam int N   = 4;
    localparam int W   = 22;
    localparam int LAT = 3;

    logic           clk;
    logic           rst;
    logic           hold;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic           cmp_less;
    logic [N-1:0]   resp_valid;
    logic           resp_less;
    logic           idle;

    cmp_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_less(cmp_less), .resp_valid(resp_valid),
        .resp_less(resp_less), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FloPoCo wE=8, wF=11 normal numbers: {exn=01, sign, exp, frac}
    function automatic logic [W-1:0] fp(input bit s, input logic [7:0] e, input logic [10:0] f);
        return {2'b01, s, e, f};
    endfunction

    function automatic bit fp_less(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [18:0] ma, mb;
        ma = a[18:0];
        mb = b[18:0];
        if (a[19] != b[19]) return a[19] && (ma != 0 || mb != 0);
        if (!a[19]) return ma < mb;
        return ma > mb;
    endfunction

    logic [W-1:0] ONE, TWO, M35, M40;
    initial begin
        ONE = fp(1'b0, 8'd127, 11'd0);
        TWO = fp(1'b0, 8'd128, 11'd0);
        M35 = fp(1'b1, 8'd128, 11'b11000000000);
        M40 = fp(1'b1, 8'd129, 11'd0);
    end

    // Environment comparator: operands registered by the DUT at edge E are
    // sampled at E+1 and the result is presented LAT edges later.
    logic cpipe [0:LAT];
    initial for (int k = 0; k <= LAT; k++) cpipe[k] = 1'b0;
    always @(posedge clk) begin
        cpipe[0] <= fp_less(cmp_a, cmp_b);
        for (int k = 1; k <= LAT; k++) cpipe[k] <= cpipe[k-1];
    end
    assign cmp_less = cpipe[LAT];

    // Behavioural model: pointer, scheduled responses, last issued operands.
    typedef struct { int due; int g; bit less; } rsp_t;
    rsp_t q[$];
    int ptr_m = 0;
    int cyc   = 0;
    int mg, cg, ri;
    bit busy;
    logic [W-1:0] ma_m = '0, mb_m = '0;
    logic [N-1:0] exp_rdy, exp_rv;
    int glog[$];
    int dlog[$];
    int rlog_g[$];
    bit rlog_l[$];

    function automatic int model_grant();
        if (hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            mg = model_grant();
            if (mg >= 0) begin
                q.push_back('{cyc + LAT + 1, mg, fp_less(req_a[mg*W +: W], req_b[mg*W +: W])});
                ma_m  = req_a[mg*W +: W];
                mb_m  = req_b[mg*W +: W];
                ptr_m = (mg + 1) % N;
                glog.push_back(mg);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            ptr_m = 0;
            ma_m  = '0;
            mb_m  = '0;
            chk(req_ready === '0, "rst_ready", req_ready, 0);
            chk(idle === 1'b1, "rst_idle", idle, 1);
            chk(resp_valid === '0, "rst_resp_valid", resp_valid, 0);
            chk(cmp_a === '0 && cmp_b === '0, "rst_cmp_ops", {cmp_a, cmp_b}, 0);
        end else begin
            cg = model_grant();
            exp_rdy = (cg >= 0) ? (N'(1) << cg) : '0;
            chk(req_ready === exp_rdy, "ready", req_ready, exp_rdy);
            if ((req_ready & req_valid) != '0) begin
                for (int k = 0; k < N; k++) if (req_ready[k]) dlog.push_back(k);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_rv = N'(1) << q[0].g;
                chk(resp_valid === exp_rv, "resp_valid", resp_valid, exp_rv);
                chk(resp_less === q[0].less, "resp_less", resp_less, q[0].less);
                void'(q.pop_front());
            end else begin
                chk(resp_valid === '0, "resp_valid_quiet", resp_valid, 0);
            end
            if (resp_valid != '0) begin
                ri = -1;
                for (int k = 0; k < N; k++) if (resp_valid[k]) ri = k;
                rlog_g.push_back(ri);
                rlog_l.push_back(resp_less);
            end
            busy = (q.size() > 0) && (q[0].due > cyc);
            chk(idle === (!busy && cg < 0), "idle", idle, (!busy && cg < 0));
            chk(cmp_a === ma_m, "cmp_a", cmp_a, ma_m);
            chk(cmp_b === mb_m, "cmp_b", cmp_b, mb_m);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        glog.delete();
        dlog.delete();
        rlog_g.delete();
        rlog_l.delete();
    endtask

    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit exp_less_by_req [N] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        tick(3);
        rst = 1'b0;

        // Round-robin with all requesters active for 8 cycles
        clear_logs();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = (i % 2 == 0) ? ONE : TWO;
            req_b[i*W +: W] = (i % 2 == 0) ? TWO : ONE;
        end
        req_valid = 4'b1111;
        tick(8);
        req_valid = '0;
        tick(8);
        chk(glog.size() == 8, "rr_model_count", glog.size(), 8);
        chk(dlog.size() == 8, "rr_dut_count", dlog.size(), 8);
        chk(rlog_g.size() == 8, "rr_resp_count", rlog_g.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < glog.size()) chk(glog[i] == exp_order[i], "rr_model_order", glog[i], exp_order[i]);
            if (i < dlog.size()) chk(dlog[i] == exp_order[i], "rr_grant_order", dlog[i], exp_order[i]);
            if (i < rlog_g.size()) chk(rlog_g[i] == exp_order[i], "rr_resp_order", rlog_g[i], exp_order[i]);
        end

        // Single request 1.0 < 2.0 on requester 0
        clear_logs();
        req_a[0 +: W] = ONE;
        req_b[0 +: W] = TWO;
        req_valid = 4'b0001;
        @(negedge clk);
        chk(req_ready === 4'b0001, "single_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(resp_valid === 4'b0001, "single_resp_valid", resp_valid, 4'b0001);
        chk(resp_less === 1'b1, "single_resp_less", resp_less, 1);
        @(negedge clk);
        chk(idle === 1'b1, "single_idle_after", idle, 1);
        tick(2);

        // Hold blocks grants, release resumes with requester 1 then 2
        hold      = 1'b1;
        req_valid = 4'b0110;
        repeat (5) begin
            @(negedge clk);
            chk(req_ready === 4'b0000, "hold_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 hold = 1'b0;
        @(negedge clk);
        chk(req_ready === 4'b0010, "hold_release_first", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk(req_ready === 4'b0100, "hold_release_second", req_ready, 4'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        tick(8);

        // Equal and negative operands under continuous contention
        clear_logs();
        req_a[0*W +: W] = ONE; req_b[0*W +: W] = TWO;
        req_a[1*W +: W] = M35; req_b[1*W +: W] = M35;
        req_a[2*W +: W] = M40; req_b[2*W +: W] = M35;
        req_a[3*W +: W] = TWO; req_b[3*W +: W] = ONE;
        req_valid = 4'b1111;
        tick(8);
        req_valid = '0;
        tick(8);
        chk(rlog_g.size() == 8, "cont_resp_count", rlog_g.size(), 8);
        for (int i = 0; i < rlog_g.size(); i++) begin
            if (rlog_g[i] >= 0) chk(rlog_l[i] == exp_less_by_req[rlog_g[i]], "cont_less_by_req",
                                    rlog_l[i], exp_less_by_req[rlog_g[i]]);
        end

        // Reset with three compares in flight
        clear_logs();
        req_valid = 4'b1111;
        tick(3);
        req_valid = '0;
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk(idle === 1'b1, "post_rst_idle", idle, 1);
        chk(rlog_g.size() == 0, "post_rst_no_resp", rlog_g.size(), 0);
        @(posedge clk);
        #1 req_valid = 4'b1010;
        @(negedge clk);
        chk(req_ready === 4'b0010, "post_rst_first_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        tick(10);
        chk(rlog_g.size() == 1, "post_rst_resp_count", rlog_g.size(), 1);
        if (rlog_g.size() > 0) chk(rlog_g[0] == 1, "post_rst_resp_req", rlog_g[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter: N, default 4, number of requesters (2..8).
REQ-002 Parameter: W, default 22, operand width (FloPoCo 11_8 format: 2 exception, sign, exponent, fraction).
REQ-003 Parameter: LAT, default 3, cycles from a cmp_a/cmp_b sample edge to the matching cmp_less value (shared less-than unit latency).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 hold  input  1  when high, blocks new grants; in-flight compares still complete.
REQ-007 req_valid  input  N  per-requester compare request.
REQ-008 req_a  input  N*W  operand A per requester; requester i uses slice [i*W +: W].
REQ-009 req_b  input  N*W  operand B per requester; same slicing as req_a.
REQ-010 req_ready  output  N  one-hot-or-zero grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-011 cmp_a  output  W  registered operand A to the shared comparator.
REQ-012 cmp_b  output  W  registered operand B to the shared comparator.
REQ-013 cmp_less  input  1  comparator result (A < B).
REQ-014 resp_valid  output  N  one-hot-or-zero, one-cycle pulse marking a result for requester i.
REQ-015 resp_less  output  1  result bit; meaningful only while any resp_valid bit is high.
REQ-016 idle  output  1  high when no compare is in flight and no grant is issued this cycle.

Function
REQ-017 req_ready shall be combinational from req_valid, hold and the priority pointer; at most one bit high per cycle.
REQ-018 hold=1 shall force req_ready to all zeros.
REQ-019 Arbitration shall be round-robin: search starts at the priority pointer ptr and takes the first i (ascending, modulo N) with req_valid[i]=1.
REQ-020 On a transfer to requester g, ptr shall become (g+1) mod N at the same edge; with no transfer, ptr is unchanged.
REQ-021 On a transfer edge, cmp_a/cmp_b shall load req_a/req_b of requester g; otherwise they hold their previous values.
REQ-022 A tag pipeline of depth LAT+1 (valid bit + requester index) shall carry each transfer; exactly one new entry is inserted per transfer edge.
REQ-023 For a transfer at edge E, resp_valid[g] shall be high during the cycle after edge E+LAT+1 and resp_less shall equal cmp_less in that cycle.
REQ-024 Throughput shall be one compare per cycle, with responses in issue order; back-to-back transfers yield back-to-back responses.
REQ-025 Responses have no backpressure: a requester must accept resp_valid whenever it is asserted.
REQ-026 A requester may hold req_valid high across consecutive cycles; each cycle in which it is granted counts as a separate transfer.
REQ-027 idle shall be low while any tag-pipeline valid bit is set or req_ready is non-zero.
REQ-028 Operand values shall pass to the comparator unmodified; the block does not interpret exception or sign bits.
REQ-029 hold asserted mid-stream shall not drop or reorder in-flight responses; deasserting hold resumes arbitration from the current ptr.

Reset
REQ-030 rst shall asynchronously clear ptr to 0, all tag-pipeline valid bits, cmp_a and cmp_b to 0, and resp_valid to 0.
REQ-031 While rst is high, req_ready shall be 0 and idle shall be 1.
REQ-032 Compares in flight when rst asserts shall be discarded; no resp_valid pulse shall be produced for them after reset.
REQ-033 The first grant after reset shall go to the lowest-indexed valid requester.

Verification
REQ-034 Single request: N=4, LAT=3, req_valid=0001, A=1.0, B=2.0 at edge E -> req_ready=0001; resp_valid=0001 with resp_less=1 in the cycle after edge E+4; idle returns to 1 afterwards.
REQ-035 Round-robin: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses arrive in the same order on consecutive cycles.
REQ-036 Hold: req_valid=0110 with hold=1 for 5 cycles -> req_ready=0000 throughout; release hold -> requester 1 is granted first, then requester 2.
REQ-037 Reset mid-flight: 3 transfers issued, rst pulsed 2 cycles later -> no resp_valid pulse ever appears; ptr=0; idle=1 after reset.
REQ-038 Equal and negative operands: A=B=-3.5 -> resp_less=0; A=-4.0, B=-3.5 -> resp_less=1; both routed to the correct requester under continuous contention.
